// File: rtl/rr_req_encoder.sv
// rr_req_encoder: 16-to-4 round-robin request encoder.
// Request strobes are captured as sticky pending bits. One pending index at a
// time is offered on SEL/GNT with a VLD/ACK handshake. A rotating search
// pointer, advanced past each accepted index, keeps the grants fair.
module rr_req_encoder #(
   parameter int N        = 16,
   parameter int SW       = 4,
   parameter int PTR_INIT = 0
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [N-1:0]  REQ,
   input  logic          ACK,
   output logic [SW-1:0] SEL,
   output logic [N-1:0]  GNT,
   output logic          VLD,
   output logic [N-1:0]  PEND
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  pend_q, pend_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [SW-1:0] ptr_q, ptr_d;

   logic [N-1:0]  clr;
   logic          found;
   logic [SW-1:0] found_idx;
   logic [SW-1:0] cand;

   assign VLD  = (state_q == GRANT);
   assign SEL  = sel_q;
   assign PEND = pend_q;
   assign GNT  = VLD ? (N'(1) << sel_q) : '0;

   // Pending bits: an accepted grant clears its bit, a same-cycle request re-sets it.
   always_comb begin
      clr = '0;
      if (VLD && ACK) clr = N'(1) << sel_q;
      pend_d = (pend_q & ~clr) | REQ;
   end

   // Wrapping search from the pointer; scanning downward leaves the nearest hit.
   always_comb begin
      found     = 1'b0;
      found_idx = '0;
      cand      = '0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = ptr_q + SW'(i);
         if (pend_q[cand]) begin
            found     = 1'b1;
            found_idx = cand;
         end
      end
   end

   // Grant FSM: pick an index when idle, hold it until acknowledged.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = found_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (ACK) begin
               ptr_d   = sel_q + SW'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any grant in flight and all pending bits.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         pend_q  <= '0;
         sel_q   <= '0;
         ptr_q   <= SW'(PTR_INIT);
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule
